// File: rtl/memif_pkg.sv
// Shared types, client base addresses and byte-lane helpers for the SDRAM arbiter.
package memif_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      ISSUE  = 3'd1,
      ACCEPT = 3'd2,
      BUSY   = 3'd3,
      ACK    = 3'd4
   } arb_state_e;

   // Client base addresses used to form CH_ADDR
   localparam logic [24:0] ROM_BASE_A  = 25'h000_0000;
   localparam logic [24:0] RAM_BASE_A  = 25'h010_0000;
   localparam logic [24:0] SRAM_BASE_A = 25'h080_0000;
   localparam logic [24:0] BMP_BASE_A  = 25'h100_0000;

   function automatic logic [3:0] byte_lane_be(input logic a0);
      return {2'b00, a0, ~a0};
   endfunction

   function automatic logic [7:0] byte_lane_sel(input logic [31:0] d, input logic a0);
      return a0 ? d[15:8] : d[7:0];
   endfunction

endpackage

// File: rtl/memif_arb_pick.sv
// Combinational grant selector; round-robin from ptr when MEMIF_SDRAM_ARB_RR_EN is defined,
// otherwise fixed priority with the lowest index winning.
module memif_arb_pick #(
   parameter int unsigned NCH = 4,
   parameter int unsigned IW  = 2
) (
   input  logic [NCH-1:0] req,
`ifdef MEMIF_SDRAM_ARB_RR_EN
   input  logic [IW-1:0]  ptr,
`endif
   output logic [NCH-1:0] gnt_c,
   output logic [IW-1:0]  idx_c,
   output logic           any_c
);

   int unsigned j;

   always_comb begin
      any_c = 1'b0;
      idx_c = '0;
      j     = 0;
      for (int unsigned k = 0; k < NCH; k++) begin
`ifdef MEMIF_SDRAM_ARB_RR_EN
         j = 32'(ptr) + k;
         if (j >= NCH) j = j - NCH;
`else
         j = k;
`endif
         if (!any_c && req[j]) begin
            any_c = 1'b1;
            idx_c = IW'(j);
         end
      end
      gnt_c = any_c ? (NCH'(1) << idx_c) : '0;
   end

endmodule

// File: rtl/memif_sdram_arb.sv
// N-channel request/ack arbiter in front of one MiSTer SDRAM controller port.
// Define MEMIF_SDRAM_ARB_RR_EN for round-robin; default build is fixed priority.
module memif_sdram_arb
   import memif_pkg::*;
#(
   parameter int unsigned    NCH     = 4,
   parameter int unsigned    AW      = 25,
   parameter int unsigned    DW      = 32,
   parameter logic [NCH-1:0] CH_BYTE = NCH'(4'b1100)
) (
   input  logic              SDRAM_CLK,
   input  logic              SDRAM_RST,
   input  logic [NCH-1:0]    CH_REQ,
   input  logic [NCH-1:0]    CH_WE,
   input  logic [NCH*AW-1:0] CH_ADDR,
   input  logic [NCH*DW-1:0] CH_DI,
   input  logic [NCH*4-1:0]  CH_BE,
   output logic [NCH-1:0]    CH_ACK,
   output logic [NCH*DW-1:0] CH_DO,
   output logic              SDRAM_CLKREF,
   output logic [AW-1:0]     SDRAM_RADDR,
   output logic [AW-1:0]     SDRAM_WADDR,
   output logic [DW-1:0]     SDRAM_DIN,
   output logic [3:0]        SDRAM_BE,
   output logic              SDRAM_RD,
   output logic              SDRAM_WE,
   input  logic              SDRAM_RD_RDY,
   input  logic              SDRAM_WE_RDY,
   input  logic [DW-1:0]     SDRAM_DOUT
);

   localparam int unsigned IW = (NCH > 1) ? $clog2(NCH) : 1;

   arb_state_e        state_q, state_d;
   logic [IW-1:0]     g_q;
   logic              we_q, byte_q;
   logic [AW-1:0]     addr_q;
   logic [DW-1:0]     din_q;
   logic [3:0]        be_q;
   logic [NCH-1:0]    ack_q;
   logic [NCH*DW-1:0] do_q;

   logic [NCH-1:0]    gnt_c;
   logic [IW-1:0]     gidx_c;
   logic              any_c, byte_c, rdy_c;
   logic              grant_c, strobe_c, done_c;

`ifdef MEMIF_SDRAM_ARB_RR_EN
   logic [IW-1:0]     ptr_q;

   always_ff @(posedge SDRAM_CLK or posedge SDRAM_RST) begin
      if (SDRAM_RST)    ptr_q <= '0;
      else if (grant_c) ptr_q <= (32'(gidx_c) == NCH - 1) ? '0 : gidx_c + IW'(1);
   end
`endif

   memif_arb_pick #(.NCH(NCH), .IW(IW)) u_pick (
      .req   (CH_REQ),
`ifdef MEMIF_SDRAM_ARB_RR_EN
      .ptr   (ptr_q),
`endif
      .gnt_c (gnt_c),
      .idx_c (gidx_c),
      .any_c (any_c)
   );

   assign byte_c = |(gnt_c & CH_BYTE);
   assign rdy_c  = we_q ? SDRAM_WE_RDY : SDRAM_RD_RDY;

   always_ff @(posedge SDRAM_CLK or posedge SDRAM_RST) begin
      if (SDRAM_RST) state_q <= IDLE;
      else           state_q <= state_d;
   end

   always_comb begin
      state_d  = state_q;
      grant_c  = 1'b0;
      strobe_c = 1'b0;
      done_c   = 1'b0;
      unique case (state_q)
         IDLE:    if (any_c && !(|ack_q)) begin
                     grant_c = 1'b1;
                     state_d = ISSUE;
                  end
         ISSUE:   if (rdy_c) begin
                     strobe_c = 1'b1;
                     state_d  = ACCEPT;
                  end
         // Controller drops RDY for one cycle after accepting a command
         ACCEPT:  state_d = BUSY;
         BUSY:    if (rdy_c) begin
                     done_c  = 1'b1;
                     state_d = ACK;
                  end
         ACK:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Grant-time latch of the transaction and completion-time read capture
   always_ff @(posedge SDRAM_CLK or posedge SDRAM_RST) begin
      if (SDRAM_RST) begin
         g_q    <= '0;
         we_q   <= 1'b0;
         byte_q <= 1'b0;
         addr_q <= '0;
         din_q  <= '0;
         be_q   <= '0;
         ack_q  <= '0;
         do_q   <= '0;
      end else begin
         ack_q <= '0;
         if (grant_c) begin
            g_q    <= gidx_c;
            we_q   <= CH_WE[gidx_c];
            byte_q <= byte_c;
            addr_q <= CH_ADDR[gidx_c*AW +: AW];
            din_q  <= byte_c ? DW'({4{CH_DI[gidx_c*DW +: 8]}}) : CH_DI[gidx_c*DW +: DW];
            be_q   <= byte_c ? byte_lane_be(CH_ADDR[gidx_c*AW]) : CH_BE[gidx_c*4 +: 4];
         end
         if (done_c) begin
            ack_q[g_q] <= 1'b1;
            if (!we_q)
               do_q[g_q*DW +: DW] <= byte_q ? DW'(byte_lane_sel(32'(SDRAM_DOUT), addr_q[0]))
                                            : SDRAM_DOUT;
         end
      end
   end

   assign SDRAM_CLKREF = |CH_REQ;
   assign SDRAM_RD     = strobe_c & ~we_q;
   assign SDRAM_WE     = strobe_c & we_q;
   assign SDRAM_RADDR  = addr_q;
   assign SDRAM_WADDR  = addr_q;
   assign SDRAM_DIN    = din_q;
   assign SDRAM_BE     = be_q;
   assign CH_ACK       = ack_q;
   assign CH_DO        = do_q;

endmodule

// File: tb/tb_memif_sdram_arb.sv
// Self-checking bench for memif_sdram_arb: directed scenarios plus randomized traffic
// against a transaction-level reference model.
module tb_memif_sdram_arb;

   localparam logic [3:0] CH_BYTE_TB = 4'b1100;
`ifdef MEMIF_SDRAM_ARB_RR_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   localparam int PH_IDLE = 0, PH_STROBE = 1, PH_GAP = 2, PH_WAIT = 3, PH_ACK = 4;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [3:0]   req = '0, we = '0;
   logic [99:0]  addr = '0;
   logic [127:0] di = '0;
   logic [15:0]  be = '0;
   logic         rd_rdy = 1'b1, wr_rdy = 1'b1;
   logic [31:0]  dout = '0;
   logic [3:0]   ack;
   logic [127:0] chdo;
   logic         clkref, rd, wr;
   logic [24:0]  raddr, waddr;
   logic [31:0]  din;
   logic [3:0]   sbe;

   int n_checks = 0, n_errors = 0;
   bit live = 1'b0;
   bit rnd_mode = 1'b0;

   memif_sdram_arb #(.NCH(4), .AW(25), .DW(32), .CH_BYTE(CH_BYTE_TB)) dut (
      .SDRAM_CLK(clk), .SDRAM_RST(rst),
      .CH_REQ(req), .CH_WE(we), .CH_ADDR(addr), .CH_DI(di), .CH_BE(be),
      .CH_ACK(ack), .CH_DO(chdo),
      .SDRAM_CLKREF(clkref), .SDRAM_RADDR(raddr), .SDRAM_WADDR(waddr),
      .SDRAM_DIN(din), .SDRAM_BE(sbe), .SDRAM_RD(rd), .SDRAM_WE(wr),
      .SDRAM_RD_RDY(rd_rdy), .SDRAM_WE_RDY(wr_rdy), .SDRAM_DOUT(dout)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
      end
   endtask

   function automatic int oh_idx(input logic [3:0] v);
      for (int i = 0; i < 4; i++) if (v[i]) return i;
      return -1;
   endfunction

   // Reference model: one outstanding transaction, phases counted per the handshake rules
   int          m_ph = PH_IDLE, m_g = 0, m_ptr = 0, m_start = 0, m_j = 0;
   bit          m_we, m_byte, m_found, m_rdy;
   logic [24:0] m_addr = '0;
   logic [31:0] m_din = '0;
   logic [3:0]  m_be = '0;
   logic [31:0] m_do [4] = '{default: '0};

   always @(negedge clk) begin
      if (live) begin
         chk("clkref", 128'(clkref), 128'(|req));
         if (rst) begin
            chk("rst_strobe", 128'({rd, wr}), 128'(0));
            chk("rst_ack", 128'(ack), 128'(0));
            chk("rst_do", chdo, 128'(0));
            chk("rst_addr", 128'({raddr, waddr}), 128'(0));
            chk("rst_din_be", 128'({din, sbe}), 128'(0));
            m_ph = PH_IDLE; m_ptr = 0; m_addr = '0; m_din = '0; m_be = '0;
            for (int i = 0; i < 4; i++) m_do[i] = '0;
         end else begin
            m_rdy = m_we ? wr_rdy : rd_rdy;
            chk("strobe", 128'({rd, wr}),
                128'({(m_ph == PH_STROBE) && !m_we && rd_rdy, (m_ph == PH_STROBE) && m_we && wr_rdy}));
            chk("ack", 128'(ack), 128'((m_ph == PH_ACK) ? (4'b0001 << m_g) : 4'b0000));
            chk("do", chdo, {m_do[3], m_do[2], m_do[1], m_do[0]});
            chk("raddr", 128'(raddr), 128'(m_addr));
            chk("waddr", 128'(waddr), 128'(m_addr));
            chk("din", 128'(din), 128'(m_din));
            chk("be", 128'(sbe), 128'(m_be));
            case (m_ph)
               PH_IDLE: begin
                  m_found = 1'b0;
                  m_start = RR ? m_ptr : 0;
                  for (int k = 0; k < 4; k++) begin
                     m_j = (m_start + k) % 4;
                     if (!m_found && req[m_j]) begin
                        m_found = 1'b1;
                        m_g     = m_j;
                     end
                  end
                  if (m_found) begin
                     m_we   = we[m_g];
                     m_byte = CH_BYTE_TB[m_g];
                     m_addr = addr[m_g*25 +: 25];
                     m_din  = m_byte ? {4{di[m_g*32 +: 8]}} : di[m_g*32 +: 32];
                     m_be   = m_byte ? (m_addr[0] ? 4'b0010 : 4'b0001) : be[m_g*4 +: 4];
                     m_ptr  = (m_g + 1) % 4;
                     m_ph   = PH_STROBE;
                  end
               end
               PH_STROBE: if (m_rdy) m_ph = PH_GAP;
               PH_GAP:    m_ph = PH_WAIT;
               PH_WAIT:   if (m_rdy) begin
                  if (!m_we) m_do[m_g] = m_byte ? ((dout >> (8 * m_addr[0])) & 32'h0000_00FF) : dout;
                  m_ph = PH_ACK;
               end
               default:   m_ph = PH_IDLE;
            endcase
         end
      end
   end

   task automatic set_ch(input int i, input bit r, input bit w, input logic [24:0] a,
                         input logic [31:0] d, input logic [3:0] b);
      req[i] = r; we[i] = w;
      addr[i*25 +: 25] = a; di[i*32 +: 32] = d; be[i*4 +: 4] = b;
   endtask

   // Advance to just after the next rising edge; in random mode also drive traffic
   task automatic cyc();
      @(posedge clk); #1;
      if (rnd_mode) begin
         for (int i = 0; i < 4; i++) begin
            if (ack[i]) begin
               if ($urandom_range(1, 0) == 0) req[i] = 1'b0;
               else set_ch(i, 1'b1, 1'($urandom_range(1, 0)), 25'($urandom), $urandom, 4'($urandom));
            end else if (!req[i] && $urandom_range(2, 0) == 0)
               set_ch(i, 1'b1, 1'($urandom_range(1, 0)), 25'($urandom), $urandom, 4'($urandom));
         end
         rd_rdy = $urandom_range(9, 0) < 7;
         wr_rdy = $urandom_range(9, 0) < 7;
         dout   = $urandom;
         rst    = ($urandom_range(799, 0) == 0);
      end
   endtask

   task automatic go(input int n);
      repeat (n) cyc();
      @(negedge clk);
   endtask

   int got_g [5];
   int n_ack;

   initial begin
      #600000;
      $display("FAIL watchdog: simulation did not finish, got %0d checks expected completion", n_checks);
      $fatal(1);
   end

   initial begin
      repeat (2) @(posedge clk);
      live = 1'b1;
      @(negedge clk);
      chk("reset_ack", 128'(ack), 128'(0));
      chk("reset_strobe", 128'({rd, wr}), 128'(0));
      chk("reset_addr", 128'(raddr), 128'(0));
      cyc(); rst = 1'b0;

      // All four channels requesting continuously
      cyc();
      set_ch(0, 1, 0, 25'h000_0010, 0, 4'hF);
      set_ch(1, 1, 0, 25'h010_0020, 0, 4'hF);
      set_ch(2, 1, 0, 25'h080_0030, 0, 4'hF);
      set_ch(3, 1, 0, 25'h100_0040, 0, 4'hF);
      dout = 32'h1234_5678;
      n_ack = 0;
      for (int c = 0; c < 80 && n_ack < 5; c++) begin
         cyc(); @(negedge clk);
         if (ack != 4'b0000) begin
            got_g[n_ack] = oh_idx(ack);
            n_ack++;
         end
      end
      chk("arb_ack_count", 128'(n_ack), 128'(5));
      for (int k = 0; k < n_ack; k++) chk("arb_order", 128'(got_g[k]), 128'(RR ? k % 4 : 0));
      cyc(); req = '0;

      // Single word read on ch1
      cyc();
      set_ch(1, 1, 0, 25'h010_0004, 0, 4'hF);
      dout = 32'hDEAD_BEEF;
      go(1);
      chk("rd1_strobe", 128'({rd, wr}), 128'(2'b10));
      chk("rd1_raddr", 128'(raddr), 128'(25'h010_0004));
      go(3);
      chk("rd1_ack", 128'(ack), 128'(4'b0010));
      chk("rd1_do", 128'(chdo[63:32]), 128'(32'hDEAD_BEEF));
      cyc(); req = '0;

      // Byte write then byte read on ch2
      cyc();
      set_ch(2, 1, 1, 25'h080_0003, 32'h0000_005A, 4'hF);
      go(1);
      chk("bw_strobe", 128'({rd, wr}), 128'(2'b01));
      chk("bw_din", 128'(din), 128'(32'h5A5A_5A5A));
      chk("bw_be", 128'(sbe), 128'(4'b0010));
      go(3);
      chk("bw_ack", 128'(ack), 128'(4'b0100));
      cyc(); req = '0;
      cyc();
      set_ch(2, 1, 0, 25'h080_0003, 0, 4'hF);
      dout = 32'h0000_A500;
      go(4);
      chk("br_ack", 128'(ack), 128'(4'b0100));
      chk("br_do", 128'(chdo[95:64]), 128'(32'h0000_00A5));
      cyc(); req = '0;

      // Read with RD_RDY held low for 10 cycles in BUSY
      cyc();
      set_ch(0, 1, 0, 25'h000_0100, 0, 4'h3);
      dout = 32'hCAFE_F00D;
      go(1);
      chk("slow_strobe", 128'({rd, wr}), 128'(2'b10));
      cyc(); rd_rdy = 1'b0;
      for (int c = 0; c < 10; c++) begin
         go(1);
         chk("slow_noack", 128'({ack, rd, wr}), 128'(0));
      end
      cyc(); rd_rdy = 1'b1;
      @(negedge clk);
      chk("slow_noack_rdy", 128'(ack), 128'(0));
      go(1);
      chk("slow_ack", 128'(ack), 128'(4'b0001));
      chk("slow_do", 128'(chdo[31:0]), 128'(32'hCAFE_F00D));
      cyc(); req = '0;

      // Reset while BUSY, then a fresh request
      cyc();
      set_ch(1, 1, 0, 25'h010_0044, 0, 4'hF);
      go(1);
      chk("rb_strobe", 128'({rd, wr}), 128'(2'b10));
      cyc(); rd_rdy = 1'b0;
      cyc(); rst = 1'b1; req = '0;
      @(negedge clk);
      chk("rb_outputs", 128'({ack, rd, wr, raddr, din, sbe}), 128'(0));
      chk("rb_do", chdo, 128'(0));
      cyc(); rst = 1'b0; rd_rdy = 1'b1;
      cyc();
      set_ch(1, 1, 0, 25'h010_0048, 0, 4'hF);
      dout = 32'h0BAD_CAFE;
      go(1);
      chk("rb_re_strobe", 128'({rd, wr}), 128'(2'b10));
      go(3);
      chk("rb_re_ack", 128'(ack), 128'(4'b0010));
      cyc(); req = '0;

      // ch3 write then immediate re-request read
      cyc();
      set_ch(3, 1, 1, 25'h100_0002, 32'h0000_00C3, 4'hF);
      go(4);
      chk("rr3_wack", 128'(ack), 128'(4'b1000));
      cyc();
      set_ch(3, 1, 0, 25'h100_0005, 0, 4'hF);
      go(1);
      chk("rr3_rd_strobe", 128'({rd, wr}), 128'(2'b10));
      chk("rr3_raddr", 128'(raddr), 128'(25'h100_0005));
      go(3);
      chk("rr3_rack", 128'(ack), 128'(4'b1000));
      cyc(); req = '0;

      // Randomized traffic
      rnd_mode = 1'b1;
      repeat (4000) cyc();
      rnd_mode = 1'b0;
      @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
